main_control: RTL and testbench
===============================

# main_control

Sequential main control unit for the single-cycle MIPS core. It decodes the 6-bit `OpCode` driven by the datapath and produces the datapath control strobes: `RegDst`, `AluSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch` and `ALUOp`. Because data memory reads are synchronous, `lw` takes two cycles. During the first of those cycles the unit holds the PC with `PCWrite`. It also counts retired and illegal instructions for debug.

## Interface
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `ILLEGAL_W`, default 8: width of the illegal-opcode counter.

- `clk`  in  1  rising-edge clock; the single clock for the whole design.
- `reset`  in  1  synchronous, active-high reset.
- `OpCode`  in  6  `Instruction[31:26]` from the datapath.
- `RegDst`, `AluSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`  out  1 each  datapath strobes.
- `ALUOp`  out  4  ALU operation class for the ALU control unit.
- `PCWrite`  out  1  PC update enable; 0 holds the current PC.
- `illegal`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `retired`  out  `RETIRE_W`  count of completed instructions; wraps.
- `illegal_cnt`  out  `ILLEGAL_W`  count of illegal opcodes; saturates.

## Operation
- States:
  - `EXEC`: normal single-cycle issue.
  - `LW_WAIT`: second cycle of a load.
- Reset behaviour: state goes to `EXEC`; both counters clear to 0. While `reset`=1, every output is 0, including `PCWrite`.
- Decode in `EXEC`. Strobes not listed for an opcode are 0.
  - R-type `000000`: `RegDst`=1, `RegWrite`=1, `ALUOp`=`0010` (funct decides), `PCWrite`=1.
  - `addi` `001000`: `AluSrc`=1, `RegWrite`=1, `ALUOp`=`0000` (add), `PCWrite`=1.
  - `sw` `101011`: `AluSrc`=1, `MemWrite`=1, `ALUOp`=`0000`, `PCWrite`=1.
  - `beq` `000100`: `Branch`=1, `ALUOp`=`0001` (subtract), `PCWrite`=1.
  - `lw` `100011`: `AluSrc`=1, `MemRead`=1, `ALUOp`=`0000`, `RegWrite`=0, `PCWrite`=0; next state is `LW_WAIT`.
  - Any other opcode: all strobes 0, `ALUOp`=`0000`, `PCWrite`=1, `illegal`=1. No architectural state changes; the instruction is skipped.
- `LW_WAIT`:
  - Outputs: `AluSrc`=1, `MemRead`=1, `MemtoReg`=1, `RegWrite`=1, `ALUOp`=`0000`, `PCWrite`=1.
  - Next state is `EXEC` unconditionally.
  - `OpCode` is ignored; it is still `lw` because the PC was held.
- Counters:
  - `retired` increments on every cycle with `PCWrite`=1 and `illegal`=0. It wraps modulo 2^`RETIRE_W`.
  - `illegal_cnt` increments on each `illegal` pulse and saturates at all-ones.

## Timing
- Every strobe is a combinational function of (state, `OpCode`) and is valid in the same cycle as `OpCode`.
- Latency:
  - `lw`: 2 cycles.
  - All other opcodes: 1 cycle.
- `MemWrite` and `RegWrite` take effect at the rising edge that ends the cycle in which they are asserted.
- Back-to-back loads: `EXEC`→`LW_WAIT`→`EXEC`→`LW_WAIT`; no bubble beyond the wait cycle.
- `reset` asserted in `LW_WAIT`: the next state is `EXEC`, and the register write is suppressed because outputs are forced to 0 while reset is high.
- Counter updates are registered; a new value is visible the cycle after the event.
- No X may appear on any output after the first reset edge, including for undefined opcodes.

## Structure
- Shared package `mips_ctrl_pkg`, holding:
  - opcode constants `OP_RTYPE`, `OP_ADDI`, `OP_LW`, `OP_SW`, `OP_BEQ`;
  - `ALUOp` constants `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`;
  - the state encoding (`EXEC`, `LW_WAIT`).
- The ALU control unit uses the same package.
- One natural sub-module, `ctrl_decode`: a purely combinational opcode-to-strobe table. The top level adds the FSM, output override, `PCWrite` and the counters.

## Test plan
- Reset then R-type: reset 2 cycles, `OpCode`=`000000` → `RegDst`=1, `RegWrite`=1, `ALUOp`=`0010`, `PCWrite`=1; `retired`=1 on the next cycle.
- Load sequence: `OpCode`=`100011` →
  - cycle 0: `MemRead`=1, `RegWrite`=0, `PCWrite`=0;
  - cycle 1: `MemtoReg`=1, `RegWrite`=1, `PCWrite`=1;
  - `retired` increments by exactly 1.
- Store and branch:
  - `101011` → `MemWrite`=1, `AluSrc`=1, `RegWrite`=0;
  - `000100` → `Branch`=1, `ALUOp`=`0001`;
  - each completes in one cycle.
- Illegal opcodes:
  - `111111` → all strobes 0, `illegal`=1, `PCWrite`=1, `retired` unchanged;
  - 300 consecutive illegal opcodes → `illegal_cnt`=255 (saturated).
- Reset mid-load: assert `reset` in the `LW_WAIT` cycle → `RegWrite`=0 that cycle; next cycle is in `EXEC`; counters are 0.
- Back-to-back `lw`, `lw`, `addi` → `PCWrite` pattern 0,1,0,1,1; `retired`=3.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS main control and ALU control units.
// Holds opcode constants, ALUOp class codes, the main-control state encoding
// and the packed strobe bundle exchanged between decode and the top level.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_FUNCT = 4'b0010;

  typedef enum logic {
    EXEC    = 1'b0,
    LW_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [3:0] alu_op;
    logic       pc_write;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode-to-strobe table used in the EXEC state.
// Ports:
//   op    in   6-bit opcode (Instruction[31:26])
//   ctrl  out  strobe bundle for that opcode; unknown opcodes flag illegal
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.pc_write  = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch    = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_write  = 1'b1;
      end
      OP_LW: begin
        // First load cycle: address goes out, PC held, no write-back yet.
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: begin
        // Unsupported opcode is skipped: advance PC, touch nothing else.
        ctrl.pc_write  = 1'b1;
        ctrl.illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/main_control.sv
// Main control unit for the single-cycle MIPS core with a two-cycle load.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   OpCode                     Instruction[31:26]
//   RegDst..Branch, ALUOp      datapath strobes (combinational on state, OpCode)
//   PCWrite                    PC update enable, low during the first lw cycle
//   illegal                    pulse for an unsupported opcode
//   retired                    wrapping count of completed instructions
//   illegal_cnt                saturating count of illegal opcodes
module main_control
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W  = 16,
  parameter int ILLEGAL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OpCode,
  output logic                 RegDst,
  output logic                 AluSrc,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 Branch,
  output logic [3:0]           ALUOp,
  output logic                 PCWrite,
  output logic                 illegal,
  output logic [RETIRE_W-1:0]  retired,
  output logic [ILLEGAL_W-1:0] illegal_cnt
);

  function automatic logic [ILLEGAL_W-1:0] sat_inc(input logic [ILLEGAL_W-1:0] v);
    return (&v) ? v : v + ILLEGAL_W'(1);
  endfunction

  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;

  ctrl_decode u_decode (
    .op   (OpCode),
    .ctrl (dec)
  );

  // Output override: reset silences everything; LW_WAIT ignores OpCode.
  always_comb begin
    ctrl = CTRL_NONE;
    if (reset) begin
      ctrl = CTRL_NONE;
    end else if (state == LW_WAIT) begin
      ctrl.alu_src    = 1'b1;
      ctrl.mem_read   = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_write  = 1'b1;
      ctrl.alu_op     = ALUOP_ADD;
      ctrl.pc_write   = 1'b1;
    end else begin
      ctrl = dec;
    end
  end

  assign RegDst   = ctrl.reg_dst;
  assign AluSrc   = ctrl.alu_src;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign ALUOp    = ctrl.alu_op;
  assign PCWrite  = ctrl.pc_write;
  assign illegal  = ctrl.illegal;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EXEC;
      retired     <= '0;
      illegal_cnt <= '0;
    end else begin
      state <= (state == EXEC && OpCode == OP_LW) ? LW_WAIT : EXEC;
      if (ctrl.pc_write && !ctrl.illegal)
        retired <= retired + RETIRE_W'(1);
      if (ctrl.illegal)
        illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

endmodule

// File: tb/tb_main_control.sv
module tb_main_control;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpCode;
  logic        RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [3:0]  ALUOp;
  logic        PCWrite, illegal;
  logic [15:0] retired;
  logic [7:0]  illegal_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  main_control #(.RETIRE_W(16), .ILLEGAL_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .RegDst      (RegDst),
    .AluSrc      (AluSrc),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Branch      (Branch),
    .ALUOp       (ALUOp),
    .PCWrite     (PCWrite),
    .illegal     (illegal),
    .retired     (retired),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  // Bundle order: RegDst AluSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[3:0] PCWrite illegal
  logic [12:0] outs;
  assign outs = {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                 ALUOp, PCWrite, illegal};

  localparam logic [12:0] V_ZERO  = 13'b0000000_0000_0_0;
  localparam logic [12:0] V_RTYPE = 13'b1001000_0010_1_0;
  localparam logic [12:0] V_ADDI  = 13'b0101000_0000_1_0;
  localparam logic [12:0] V_SW    = 13'b0100010_0000_1_0;
  localparam logic [12:0] V_BEQ   = 13'b0000001_0001_1_0;
  localparam logic [12:0] V_LW0   = 13'b0100100_0000_0_0;
  localparam logic [12:0] V_LW1   = 13'b0111100_0000_1_0;
  localparam logic [12:0] V_ILL   = 13'b0000000_0000_1_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    OpCode = OP_RTYPE;
    tick();
    tick();
    #2;
    chk("reset_outs", 32'(outs), 32'(V_ZERO));
    chk("reset_retired", 32'(retired), 0);
    chk("reset_illcnt", 32'(illegal_cnt), 0);

    // R-type after reset
    reset  = 1'b0;
    OpCode = OP_RTYPE;
    #2;
    chk("rtype_outs", 32'(outs), 32'(V_RTYPE));
    tick();
    chk("rtype_retired", 32'(retired), 1);

    // Load: two cycles, one retirement
    OpCode = OP_LW;
    #2;
    chk("lw_c0_outs", 32'(outs), 32'(V_LW0));
    tick();
    #2;
    chk("lw_c1_outs", 32'(outs), 32'(V_LW1));
    chk("lw_c1_retired", 32'(retired), 1);
    tick();
    chk("lw_retired", 32'(retired), 2);

    // Store, branch, addi: one cycle each
    OpCode = OP_SW;
    #2;
    chk("sw_outs", 32'(outs), 32'(V_SW));
    tick();
    chk("sw_retired", 32'(retired), 3);
    OpCode = OP_BEQ;
    #2;
    chk("beq_outs", 32'(outs), 32'(V_BEQ));
    tick();
    chk("beq_retired", 32'(retired), 4);
    OpCode = OP_ADDI;
    #2;
    chk("addi_outs", 32'(outs), 32'(V_ADDI));
    tick();
    chk("addi_retired", 32'(retired), 5);

    // Illegal opcode
    OpCode = 6'b111111;
    #2;
    chk("ill_outs", 32'(outs), 32'(V_ILL));
    tick();
    chk("ill_retired", 32'(retired), 5);
    chk("ill_cnt1", 32'(illegal_cnt), 1);

    // 299 more illegal opcodes, 300 in total: saturate at 255
    for (int i = 0; i < 299; i++) begin
      OpCode = (i % 2 == 1) ? 6'b111111 : 6'b000010;
      #2;
      if (i == 0) chk("ill_j_outs", 32'(outs), 32'(V_ILL));
      tick();
      if (i == 252) chk("ill_cnt254", 32'(illegal_cnt), 254);
    end
    chk("ill_cnt_sat", 32'(illegal_cnt), 255);
    chk("ill_sat_retired", 32'(retired), 5);

    // Reset asserted in LW_WAIT
    OpCode = OP_LW;
    #2;
    chk("rst_lw_c0", 32'(outs), 32'(V_LW0));
    tick();
    reset = 1'b1;
    #2;
    chk("rst_lw_c1_outs", 32'(outs), 32'(V_ZERO));
    tick();
    reset = 1'b0;
    chk("rst_lw_retired", 32'(retired), 0);
    chk("rst_lw_illcnt", 32'(illegal_cnt), 0);
    #2;
    // Still lw on the bus: EXEC decode must show the first load cycle.
    chk("rst_lw_exec", 32'(outs), 32'(V_LW0));

    // Back-to-back lw, lw, addi: PCWrite 0,1,0,1,1
    chk("b2b_pcw0", 32'(PCWrite), 0);
    tick();
    #2;
    chk("b2b_c1", 32'(outs), 32'(V_LW1));
    tick();
    #2;
    chk("b2b_c2", 32'(outs), 32'(V_LW0));
    tick();
    #2;
    chk("b2b_c3", 32'(outs), 32'(V_LW1));
    tick();
    OpCode = OP_ADDI;
    #2;
    chk("b2b_c4", 32'(outs), 32'(V_ADDI));
    tick();
    chk("b2b_retired", 32'(retired), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
